// File: rtl/conv_kernel_ctrl.sv
// Issue-side sequencer for the 4-lane FP convolution data path.
// Walks beats per output pixel, drives in_fm/weight buffer reads, pulses
// kernel_start on each pixel's first beat, and schedules the out_fm
// read-modify-write through a fixed-depth shift pipe of last-beat flags.
// Optional feature macro: CONV_CTRL_PERF_EN (adds perf_cycles output).
module conv_kernel_ctrl #(
  parameter int AW             = 10,
  parameter int PW             = 10,
  parameter int BW             = 8,
  parameter int BUF_RD_DELAY   = 1,
  parameter int OUT_RD_DELAY   = 1,
  parameter int FP_MUL_DELAY   = 11,
  parameter int FP_ADD_DELAY   = 14,
  parameter int FP_ACCUM_DELAY = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] pix_num,
  input  logic [BW-1:0] beat_num,
  output logic          busy,
  output logic          done,
  output logic          in_fm_rd_ena,
  output logic [AW-1:0] in_fm_rd_addr,
  output logic [AW-1:0] weight_rd_addr,
  output logic          kernel_start,
  output logic          out_fm_rd_ena,
  output logic [AW-1:0] out_fm_rd_addr,
  output logic          out_fm_wr_ena,
  output logic [AW-1:0] out_fm_wr_addr
`ifdef CONV_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_cycles
`endif
);

  localparam int ACC_LAT = BUF_RD_DELAY + FP_MUL_DELAY + 2*FP_ADD_DELAY + FP_ACCUM_DELAY;
  // A flag entering the pipe at issue cycle L is visible in stage k at L+1+k.
  localparam int RD_TAP  = ACC_LAT - OUT_RD_DELAY;
  localparam int WR_TAP  = ACC_LAT + FP_ADD_DELAY;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pix_tot_q, pix_tot_d;
  logic [BW-1:0] beat_tot_q, beat_tot_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [AW-1:0] in_addr_q, in_addr_d;
  logic [WR_TAP-1:0] vld_q, vld_d;
  logic [AW-1:0] paddr_q [WR_TAP];
  logic [AW-1:0] paddr_d [WR_TAP];

  logic issue;
  logic last_beat;
  logic last_pix;

  // Next-state, counters and pipe shift
  always_comb begin
    state_d    = state_q;
    pix_tot_d  = pix_tot_q;
    beat_tot_d = beat_tot_q;
    pix_d      = pix_q;
    beat_d     = beat_q;
    in_addr_d  = in_addr_q;
    issue      = (state_q == RUN);
    last_beat  = issue && (beat_q == beat_tot_q - BW'(1));
    last_pix   = (pix_q == pix_tot_q - PW'(1));

    unique case (state_q)
      IDLE: begin
        if (start) begin
          pix_tot_d  = pix_num;
          beat_tot_d = beat_num;
          pix_d      = '0;
          beat_d     = '0;
          in_addr_d  = '0;
          // Empty runs skip straight to drain, whose pipe is already empty.
          state_d    = (pix_num == '0 || beat_num == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        in_addr_d = in_addr_q + AW'(1);
        if (last_beat) begin
          beat_d = '0;
          pix_d  = pix_q + PW'(1);
          if (last_pix) state_d = DRAIN;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      DRAIN: begin
        // Leave once only the final write stage (or nothing) remains.
        if (vld_q[WR_TAP-2:0] == '0) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    vld_d[0]   = last_beat;
    paddr_d[0] = AW'(pix_q);
    for (int unsigned k = 1; k < WR_TAP; k++) begin
      vld_d[k]   = vld_q[k-1];
      paddr_d[k] = paddr_q[k-1];
    end
  end

  // State, counter and pipe registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pix_tot_q  <= '0;
      beat_tot_q <= '0;
      pix_q      <= '0;
      beat_q     <= '0;
      in_addr_q  <= '0;
      vld_q      <= '0;
      for (int unsigned k = 0; k < WR_TAP; k++) paddr_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      pix_tot_q  <= pix_tot_d;
      beat_tot_q <= beat_tot_d;
      pix_q      <= pix_d;
      beat_q     <= beat_d;
      in_addr_q  <= in_addr_d;
      vld_q      <= vld_d;
      for (int unsigned k = 0; k < WR_TAP; k++) paddr_q[k] <= paddr_d[k];
    end
  end

  // Output decode from registered state
  always_comb begin
    busy           = (state_q == RUN) || (state_q == DRAIN);
    done           = (state_q == DONE);
    in_fm_rd_ena   = issue;
    in_fm_rd_addr  = in_addr_q;
    weight_rd_addr = AW'(beat_q);
    kernel_start   = issue && (beat_q == '0);
    out_fm_rd_ena  = vld_q[RD_TAP-1];
    out_fm_rd_addr = paddr_q[RD_TAP-1];
    out_fm_wr_ena  = vld_q[WR_TAP-1];
    out_fm_wr_addr = paddr_q[WR_TAP-1];
  end

`ifdef CONV_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Run-length counter: includes the done cycle, holds while idle
  always_comb begin
    perf_d = perf_q;
    if (state_q == IDLE) begin
      if (start) perf_d = '0;
    end else begin
      perf_d = perf_q + 32'd1;
    end
  end

  // Perf counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_q <= '0;
    else      perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_conv_kernel_ctrl.sv
// Directed self-checking bench for conv_kernel_ctrl (default parameters).
// Expected waveforms are closed-form in cycle index c, where cycle 0 is the
// cycle in which start is sampled.
module tb_conv_kernel_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] pix_num;
  logic [7:0] beat_num;
  logic       busy, done, in_fm_rd_ena, kernel_start;
  logic       out_fm_rd_ena, out_fm_wr_ena;
  logic [9:0] in_fm_rd_addr, weight_rd_addr, out_fm_rd_addr, out_fm_wr_addr;
`ifdef CONV_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int checks = 0;
  int errors = 0;

  conv_kernel_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pix_num        (pix_num),
    .beat_num       (beat_num),
    .busy           (busy),
    .done           (done),
    .in_fm_rd_ena   (in_fm_rd_ena),
    .in_fm_rd_addr  (in_fm_rd_addr),
    .weight_rd_addr (weight_rd_addr),
    .kernel_start   (kernel_start),
    .out_fm_rd_ena  (out_fm_rd_ena),
    .out_fm_rd_addr (out_fm_rd_addr),
    .out_fm_wr_ena  (out_fm_wr_ena),
    .out_fm_wr_addr (out_fm_wr_addr)
`ifdef CONV_CTRL_PERF_EN
    ,
    .perf_cycles    (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc %0d: observed %0d expected %0d", tag, c, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag, input int c);
    chk({tag, "_busy"},   c, 32'(busy), 0);
    chk({tag, "_done"},   c, 32'(done), 0);
    chk({tag, "_rd"},     c, 32'(in_fm_rd_ena), 0);
    chk({tag, "_inaddr"}, c, 32'(in_fm_rd_addr), 0);
    chk({tag, "_waddr"},  c, 32'(weight_rd_addr), 0);
    chk({tag, "_ks"},     c, 32'(kernel_start), 0);
    chk({tag, "_ord"},    c, 32'(out_fm_rd_ena), 0);
    chk({tag, "_oraddr"}, c, 32'(out_fm_rd_addr), 0);
    chk({tag, "_owr"},    c, 32'(out_fm_wr_ena), 0);
    chk({tag, "_owaddr"}, c, 32'(out_fm_wr_addr), 0);
  endtask

  // Run one job of P pixels x B beats, checking cycles 1..n. start stays high
  // through cycle 'hold'. abort_at>0 pulls reset low in that cycle.
  task automatic run(input int P, input int B, input int hold, input int n, input int abort_at);
    int nb;
    bit zero;
    bit e_rd, e_ks, e_ord, e_wr, e_done, e_busy;
    nb   = P * B;
    zero = (P == 0 || B == 0);
    @(negedge clk);
    pix_num  = 10'(P);
    beat_num = 8'(B);
    start    = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= n; c++) begin
      if (c > hold) start = 1'b0;
      if (c == abort_at) begin
        rst = 1'b0;
        #1;
        chk_all_zero("abort", c);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 80; k++) begin
          @(posedge clk); #1;
          chk("post_abort_owr",  k, 32'(out_fm_wr_ena), 0);
          chk("post_abort_ord",  k, 32'(out_fm_rd_ena), 0);
          chk("post_abort_done", k, 32'(done), 0);
          chk("post_abort_rd",   k, 32'(in_fm_rd_ena), 0);
        end
        return;
      end
      if (zero) begin
        e_rd = 0; e_ks = 0; e_ord = 0; e_wr = 0;
        e_busy = (c == 1);
        e_done = (c == 2);
      end else begin
        e_rd   = (c >= 1 && c <= nb);
        e_ks   = e_rd && ((c - 1) % B == 0);
        e_ord  = (c >= B + 48 && c <= nb + 48 && (c - 48) % B == 0);
        e_wr   = (c >= B + 63 && c <= nb + 63 && (c - 63) % B == 0);
        e_busy = (c >= 1 && c <= nb + 63);
        e_done = (c == nb + 64);
      end
      chk("rd_ena",  c, 32'(in_fm_rd_ena), 32'(e_rd));
      chk("kstart",  c, 32'(kernel_start), 32'(e_ks));
      chk("ofm_rd",  c, 32'(out_fm_rd_ena), 32'(e_ord));
      chk("ofm_wr",  c, 32'(out_fm_wr_ena), 32'(e_wr));
      chk("busy",    c, 32'(busy), 32'(e_busy));
      chk("done",    c, 32'(done), 32'(e_done));
      if (e_rd) begin
        chk("in_addr", c, 32'(in_fm_rd_addr), 32'(c - 1));
        chk("w_addr",  c, 32'(weight_rd_addr), 32'((c - 1) % B));
      end
      if (e_ord) chk("ofm_rd_addr", c, 32'(out_fm_rd_addr), 32'((c - 48) / B - 1));
      if (e_wr)  chk("ofm_wr_addr", c, 32'(out_fm_wr_addr), 32'((c - 63) / B - 1));
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pix_num = '0; beat_num = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset", 0);
`ifdef CONV_CTRL_PERF_EN
    chk("reset_perf", 0, perf_cycles, 0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // 1 pixel x 4 beats, start held high through cycle 50 (must not re-trigger)
    run(1, 4, 50, 70, 0);
`ifdef CONV_CTRL_PERF_EN
    chk("perf_t1", 70, perf_cycles, 68);
`endif
    // 3 pixels x 2 beats
    run(3, 2, 0, 72, 0);
    // 4 pixels x 1 beat: back-to-back rd/wr strobes
    run(4, 1, 0, 70, 0);
    // Empty runs
    run(0, 5, 0, 5, 0);
    run(3, 0, 0, 5, 0);
    // Abort mid-run with pixels in flight, then a fresh run must work
    run(3, 2, 0, 40, 30);
    run(4, 1, 0, 70, 0);
`ifdef CONV_CTRL_PERF_EN
    chk("perf_t3", 70, perf_cycles, 68);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
